branch_predictor_ctrl: RTL and testbench

- Sequencer for the 2-bit-counter branch history table (BHT) and branch target buffer (BTB) in the fetch predictor.
- After reset it clears every table entry with a one-entry-per-cycle walk.
- It queues branch resolutions from EX in a small FIFO and drains them into saturating counter updates and BTB target writes through a single table write port.
- It also raises the mispredict redirect toward IF.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_resolve_fifo.sv | 71 +++++++
 rtl/branch_predictor_ctrl.sv | 158 +++++++++++++++
 tb/tb_branch_predictor_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor control slice.
//   - 2-bit counter encodings for the branch history table
//   - controller FSM state encoding
//   - sat2(): 2-bit saturating counter update
package bp_pkg;

  localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
  localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPDATE = 2'd2
  } bp_state_e;

  // Move the counter one step toward the resolved direction, holding at the ends.
  function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == STRONGLY_TAKEN) ? cnt : cnt + 2'd1;
    end else begin
      res = (cnt == STRONGLY_NOT_TAKEN) ? cnt : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_resolve_fifo.sv
// bp_resolve_fifo: synchronous FIFO holding branch resolutions until the
// single table write port is free.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data      write request / data (ignored when full)
//   i_pop               read request (ignored when empty)
//   o_data              head entry, combinational from storage
//   o_full, o_empty     flags derived from the registered count
//   o_count             number of stored entries, log2(DEPTH)+1 bits
module bp_resolve_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// branch_predictor_ctrl: sequencer for the 2-bit BHT and the BTB.
// After reset it clears the table one entry per cycle, then drains queued EX
// branch resolutions into saturating counter updates and BTB target writes
// through a single write port. It also produces the registered mispredict
// redirect toward IF.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ex_*_i                  EX-stage branch resolution inputs
//   stall_o                 resolution FIFO full; EX must hold its inputs
//   init_done_o             table clear walk finished
//   tbl_we_o/idx_o/wdata_o  BHT write port (idx also addresses the read)
//   tbl_rdata_i             BHT counter at tbl_idx_o, combinational
//   btb_we_o, btb_tgt_o     BTB write port (same index as the BHT)
//   mispredict_o            one-cycle pulse, prediction was wrong
//   redirect_pc_o           correct fetch PC while mispredict_o is high
module branch_predictor_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_taken_i,
  input  logic             ex_pred_taken_i,
  input  logic [31:0]      ex_target_i,
  output logic             stall_o,
  output logic             init_done_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_idx_o,
  input  logic [1:0]       tbl_rdata_i,
  output logic [1:0]       tbl_wdata_o,
  output logic             btb_we_o,
  output logic [31:0]      btb_tgt_o,
  output logic             mispredict_o,
  output logic [31:0]      redirect_pc_o
);

  localparam int ENT_W = IDX_W + 1 + 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  bp_state_e        r_state;
  bp_state_e        w_state_next;
  logic [IDX_W-1:0] r_walk_idx;
  logic             r_init_done;
  logic             r_mispredict;
  logic [31:0]      r_redirect_pc;

  logic             w_enq;
  logic             w_deq;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [ENT_W-1:0] w_enq_data;
  logic [ENT_W-1:0] w_head;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_taken;
  logic [31:0]      w_head_tgt;
  logic             w_walk_last;
  logic             w_mp_fire;

  // FIFO entry layout: {index, taken, target}
  assign w_enq_data   = {ex_pc_i[IDX_W+1:2], ex_taken_i, ex_target_i};
  assign w_head_idx   = w_head[ENT_W-1 -: IDX_W];
  assign w_head_taken = w_head[32];
  assign w_head_tgt   = w_head[31:0];

  assign w_enq       = ex_valid_i && ex_is_branch_i && !w_full;
  assign w_deq       = (r_state != INIT) && !w_empty;
  assign w_walk_last = (r_walk_idx == {IDX_W{1'b1}});
  assign w_mp_fire   = ex_valid_i && ex_is_branch_i && (ex_taken_i != ex_pred_taken_i);

  assign stall_o       = w_full;
  assign init_done_o   = r_init_done;
  assign mispredict_o  = r_mispredict;
  assign redirect_pc_o = r_redirect_pc;

  bp_resolve_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_enq),
    .i_data  (w_enq_data),
    .i_pop   (w_deq),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= INIT;
      r_walk_idx    <= '0;
      r_init_done   <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == INIT) begin
        r_walk_idx <= r_walk_idx + IDX_W'(1);
        if (w_walk_last) begin
          r_init_done <= 1'b1;
        end
      end
      r_mispredict <= w_mp_fire;
      if (w_mp_fire) begin
        r_redirect_pc <= ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
      end
    end
  end

  // Next state plus the table write port. UPDATE marks that the FIFO will
  // hold an entry next cycle; draining itself only depends on "not INIT".
  // Write enables are held low while reset is asserted so a long reset does
  // not keep rewriting entry 0.
  always_comb begin
    w_state_next = r_state;
    tbl_we_o     = 1'b0;
    tbl_idx_o    = '0;
    tbl_wdata_o  = STRONGLY_NOT_TAKEN;
    btb_we_o     = 1'b0;
    btb_tgt_o    = '0;

    case (r_state)
      INIT: begin
        if (w_walk_last) begin
          w_state_next = IDLE;
        end
      end
      IDLE, UPDATE: begin
        w_state_next = (w_enq || (w_count > CNT_W'(1))) ? UPDATE : IDLE;
      end
      default: w_state_next = INIT;
    endcase

    if (!rst_i) begin
      if (r_state == INIT) begin
        tbl_we_o  = 1'b1;
        tbl_idx_o = r_walk_idx;
      end else if (w_deq) begin
        // The table is write-first, so back-to-back entries on one index
        // see the value written on the previous edge.
        tbl_we_o    = 1'b1;
        tbl_idx_o   = w_head_idx;
        tbl_wdata_o = sat2(tbl_rdata_i, w_head_taken);
        btb_we_o    = w_head_taken;
        btb_tgt_o   = w_head_tgt;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
module tb_branch_predictor_ctrl;

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             ex_valid_i = 1'b0;
  logic             ex_is_branch_i = 1'b0;
  logic [31:0]      ex_pc_i = '0;
  logic             ex_taken_i = 1'b0;
  logic             ex_pred_taken_i = 1'b0;
  logic [31:0]      ex_target_i = '0;
  logic             stall_o;
  logic             init_done_o;
  logic             tbl_we_o;
  logic [IDX_W-1:0] tbl_idx_o;
  logic [1:0]       tbl_rdata_i;
  logic [1:0]       tbl_wdata_o;
  logic             btb_we_o;
  logic [31:0]      btb_tgt_o;
  logic             mispredict_o;
  logic [31:0]      redirect_pc_o;

  always #5 clk = ~clk;

  branch_predictor_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ex_valid_i      (ex_valid_i),
    .ex_is_branch_i  (ex_is_branch_i),
    .ex_pc_i         (ex_pc_i),
    .ex_taken_i      (ex_taken_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .ex_target_i     (ex_target_i),
    .stall_o         (stall_o),
    .init_done_o     (init_done_o),
    .tbl_we_o        (tbl_we_o),
    .tbl_idx_o       (tbl_idx_o),
    .tbl_rdata_i     (tbl_rdata_i),
    .tbl_wdata_o     (tbl_wdata_o),
    .btb_we_o        (btb_we_o),
    .btb_tgt_o       (btb_tgt_o),
    .mispredict_o    (mispredict_o),
    .redirect_pc_o   (redirect_pc_o)
  );

  // BHT storage: combinational read, write on the clock edge.
  logic [1:0] bht_mem [N];
  assign tbl_rdata_i = bht_mem[tbl_idx_o];
  always @(posedge clk) begin
    if (tbl_we_o) bht_mem[tbl_idx_o] <= tbl_wdata_o;
  end

  // Reference model: queue of pending resolutions plus the table contents.
  typedef struct {
    int          idx;
    bit          taken;
    logic [31:0] tgt;
  } res_t;

  res_t        q[$];
  int          ref_bht[N];
  bit          walking;
  int          widx;
  bit          done;
  bit          mp;
  logic [31:0] rpc;
  bit          chk_rpc;
  bit          known;
  int          total;
  int          bad;

  function automatic int sat(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    res_t h;
    int   pre;
    bit   fire;
    @(negedge clk);
    if (rst_i) begin
      chk("we_in_reset", tbl_we_o, 0);
      chk("btb_we_in_reset", btb_we_o, 0);
    end else if (walking) begin
      chk("walk_we", tbl_we_o, 1);
      chk("walk_idx", tbl_idx_o, widx);
      chk("walk_wdata", tbl_wdata_o, 0);
      chk("walk_btb_we", btb_we_o, 0);
    end else if (q.size() > 0) begin
      h = q[0];
      chk("drain_we", tbl_we_o, 1);
      chk("drain_idx", tbl_idx_o, h.idx);
      chk("drain_wdata", tbl_wdata_o, sat(ref_bht[h.idx], h.taken));
      chk("drain_btb_we", btb_we_o, h.taken);
      if (h.taken) chk("drain_btb_tgt", btb_tgt_o, h.tgt);
    end else begin
      chk("empty_we", tbl_we_o, 0);
      chk("empty_btb_we", btb_we_o, 0);
      chk("empty_idx", tbl_idx_o, 0);
    end
    if (known) begin
      chk("stall", stall_o, (q.size() == DEPTH) ? 1 : 0);
      chk("init_done", init_done_o, done);
      chk("mispredict", mispredict_o, mp);
      if (chk_rpc) chk("redirect_pc", redirect_pc_o, rpc);
    end
    @(posedge clk);
    if (rst_i) begin
      q.delete();
      walking = 1;
      widx    = 0;
      done    = 0;
      mp      = 0;
      rpc     = '0;
      chk_rpc = 1;
    end else begin
      pre  = q.size();
      fire = ex_valid_i && ex_is_branch_i && (ex_taken_i != ex_pred_taken_i);
      mp      = fire;
      chk_rpc = fire;
      if (fire) rpc = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
      if (walking) begin
        ref_bht[widx] = 0;
        if (widx == N - 1) begin
          walking = 0;
          done    = 1;
        end else begin
          widx++;
        end
      end else if (pre > 0) begin
        h = q.pop_front();
        ref_bht[h.idx] = sat(ref_bht[h.idx], h.taken);
      end
      if (ex_valid_i && ex_is_branch_i && pre < DEPTH) begin
        h.idx   = int'((ex_pc_i >> 2) & 32'(N - 1));
        h.taken = ex_taken_i;
        h.tgt   = ex_target_i;
        q.push_back(h);
      end
    end
    known = 1;
    #1;
  endtask

  task automatic idle(input int n);
    ex_valid_i     = 1'b0;
    ex_is_branch_i = 1'b0;
    repeat (n) tick();
  endtask

  // Present one branch and hold it while the FIFO is full, bounded.
  task automatic send(input logic [31:0] pc, input bit taken, input bit pred,
                      input logic [31:0] tgt);
    bit ok;
    bit was_full;
    ex_valid_i      = 1'b1;
    ex_is_branch_i  = 1'b1;
    ex_pc_i         = pc;
    ex_taken_i      = taken;
    ex_pred_taken_i = pred;
    ex_target_i     = tgt;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      was_full = (q.size() == DEPTH);
      tick();
      if (!was_full) begin
        ok = 1;
        break;
      end
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic pulse_reset();
    ex_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    known = 0;

    // Reset and the first clear walk.
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    idle(N + 2);

    // Saturation on one index: five taken, then three not taken.
    for (int i = 0; i < 5; i++) send(32'h40, 1, 1, 32'h1000 + 32'(i));
    for (int i = 0; i < 3; i++) send(32'h40, 0, 0, 32'h2000 + 32'(i));
    idle(3);

    // Mispredict redirects, including the 32-bit wrap of pc+4.
    send(32'h100, 1, 0, 32'h200);
    idle(2);
    send(32'hFFFF_FFFC, 0, 1, 32'h1234);
    idle(2);

    // FIFO full during the walk: fifth branch waits for the first drain.
    pulse_reset();
    for (int i = 0; i < 5; i++) send(32'h0 + 32'(4 * i), i[0], i[0], 32'h3000 + 32'(i));
    idle(6);

    // Reset mid-drain discards queued entries and restarts the walk.
    pulse_reset();
    for (int i = 0; i < 3; i++) send(32'h20 + 32'(4 * i), 1, 1, 32'h4000 + 32'(i));
    idle(N - 3 + 1);
    pulse_reset();
    idle(N + 3);

    // Steady one branch per cycle with two entries queued.
    pulse_reset();
    send(32'h8, 1, 1, 32'h5000);
    send(32'hC, 0, 0, 32'h5004);
    idle(N - 2);
    for (int i = 0; i < 12; i++) begin
      send(32'h8000_0000 + 32'($urandom_range(0, 3) << 2), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom());
    end
    idle(4);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      if (q.size() != DEPTH) begin
        ex_valid_i      = ($urandom_range(0, 3) != 0);
        ex_is_branch_i  = ($urandom_range(0, 2) != 0);
        ex_pc_i         = 32'h8000_0000 + 32'($urandom_range(0, 5) << 2);
        ex_taken_i      = 1'($urandom_range(0, 1));
        ex_pred_taken_i = 1'($urandom_range(0, 1));
        ex_target_i     = $urandom();
      end
      rst_i = ($urandom_range(0, 149) == 0);
      tick();
      rst_i = 1'b0;
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
